score_scan_ctrl: RTL
====================

# score_scan_ctrl

Game-side controller for the Flappy Bird score display. It owns the current score and best score as packed BCD and sequences the game states IDLE, PLAY and OVER. It time-multiplexes both values onto the 8-digit seven-segment bank, with leading-zero blanking and game-over flashing. It sits between the game FSM (pulse inputs) and the segment decoder (`digit`, `blank`, `an`).

## Interface
- `SCAN_DIV`, default 50000: clk cycles each digit slot is driven (≥2).
- `FLASH_DIV`, default 24: full 8-slot frames per flash half-period (≥1).
- `clk` input 1: system clock; the only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `game_start` input 1: single-cycle pulse that clears the current score and enters PLAY.
- `game_over` input 1: single-cycle pulse that commits the best score and enters OVER.
- `point` input 1: single-cycle pulse, bird passed a pipe.
- `score_bcd` output 16: current score, 4 BCD digits, [3:0] = ones.
- `best_bcd` output 16: best score, 4 BCD digits.
- `new_best` output 1: the last game_over raised the best score.
- `digit` output 4: BCD nibble for the decoder.
- `blank` output 1: the current slot is suppressed.
- `an` output 8: digit enables, active-low, at most one bit low.

## Operation
- States: IDLE (reset), PLAY, OVER.
- Priority within a cycle: `game_start` > `game_over` > `point`. Lower-priority pulses in the same cycle are dropped.
- `game_start` in any state: state becomes PLAY, score_bcd becomes 0, new_best becomes 0. best_bcd is unchanged.
- `game_over` in PLAY only: state becomes OVER. If score_bcd > best_bcd, then best_bcd becomes score_bcd and new_best becomes 1. The comparison is an unsigned compare of the packed BCD vectors. `game_over` is ignored in IDLE and OVER.
- `point` in PLAY only: score_bcd increments by one in decimal.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - At 9999 the score saturates and holds 9999.
  - `point` is ignored in IDLE and OVER.
- Slot layout: slots 0-3 carry score_bcd digits 0-3 on an[0]..an[3]. Slots 4-7 carry best_bcd digits 0-3 on an[4]..an[7].
- Leading-zero blanking, per 4-digit group: digit k (k = 1..3) is blanked when it and every higher digit of its group are 0. Digit 0 is never blanked by this rule.
- Flashing: a phase bit toggles every FLASH_DIV completed frames. A frame is slot 7 followed by slot 0.
  - In OVER with phase = 0, slots 0-3 are blanked.
  - If new_best is also 1, slots 4-7 are blanked as well.
  - Outside OVER, the flash phase is forced to 1 and the frame counter is held at 0.
- Blanked slot: `an` = 8'hFF and `blank` = 1. `digit` still carries the nibble.
- Otherwise: `an` = ~(1 << slot) and `blank` = 0.

## Timing
- Reset values:
  - state IDLE
  - score_bcd 16'h0000, best_bcd 16'h0000, new_best 0
  - slot 0, slot-cycle counter 0, frame counter 0, phase 1
  - digit 0, blank 1, an 8'hFF
- Every output is registered.
- score_bcd, best_bcd and new_best change on the first clk edge after the input pulse (latency 1).
- Scan: a slot counter counts 0..SCAN_DIV-1. The slot advances (7 wraps to 0) when the counter wraps.
- digit, blank and an reflect the current slot, score and phase with one cycle of latency.
- The first valid drive is on the first edge after `rst` deasserts: slot 0, an 8'hFE, digit 0, blank 0.
- A score change mid-slot appears on the next cycle, without waiting for a slot boundary.
- `rst` asserted mid-frame or mid-game forces all reset values immediately, asynchronously. best_bcd is lost.
- No handshake: a pulse held for N cycles counts as N events (e.g. `point` held 3 cycles in PLAY adds 3).

## Test plan
- Reset, then `game_start`, then 12 `point` pulses -> score_bcd 16'h0012. Sequence: …9 → 10 → 11 → 12, no hex values. an walks FE,FD,FF,FF,EF,FF,FF,FF with SCAN_DIV=4. Slots 2 and 3 are blanked, and the best group shows a lone 0.
- Preload score to 9998 via `point` in PLAY, then 3 `point` pulses -> 9999 held, no wrap.
- Score 0042 with best 0030, then `game_over` -> best_bcd 16'h0042 and new_best 1. With FLASH_DIV=2, slots 0-7 blank for 2 frames and are visible for 2 frames, alternating. A second game with score 0010 and `game_over` -> best stays 0042, new_best 0, only slots 0-3 flash.
- Same-cycle `point` + `game_over` in PLAY at score 0005 -> score stays 0005, state OVER. Same-cycle `game_start` + `game_over` -> PLAY, score 0.
- `point` and `game_over` in IDLE, and `point` in OVER -> no change to score, best or state.
- `rst` pulsed mid-slot 5 during OVER flash -> an 8'hFF and blank 1 immediately, all registers at reset values. After release, the scan restarts at slot 0.

Source files
------------

// File: rtl/score_scan_ctrl.sv
// ---------------------------------------------------------------------------
// score_scan_ctrl
//
// Game-side controller for the Flappy Bird score display.  Tracks the game
// state (IDLE / PLAY / OVER), keeps the current and best score as packed BCD,
// and time-multiplexes both values onto an 8-digit seven-segment bank with
// leading-zero blanking and game-over flashing.
//
// Parameters
//   SCAN_DIV   clk cycles each digit slot is driven (>= 2)
//   FLASH_DIV  completed 8-slot frames per flash half-period (>= 1)
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   game_start  pulse: clear score, enter PLAY (highest priority)
//   game_over   pulse: in PLAY, commit best score and enter OVER
//   point       pulse: in PLAY, add one to the score (saturates at 9999)
//   score_bcd   current score, 4 BCD digits, [3:0] = ones
//   best_bcd    best score, 4 BCD digits
//   new_best    last game_over raised the best score
//   digit       BCD nibble of the slot being driven
//   blank       slot is suppressed
//   an          digit enables, active-low, at most one bit low
// ---------------------------------------------------------------------------
module score_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int FLASH_DIV = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        point,
    output logic [15:0] score_bcd,
    output logic [15:0] best_bcd,
    output logic        new_best,
    output logic [3:0]  digit,
    output logic        blank,
    output logic [7:0]  an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FR_W  = $clog2(FLASH_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [FR_W-1:0]  FR_MAX  = FR_W'(FLASH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] score_reg, score_next;
    logic [15:0] best_reg,  best_next;
    logic        new_best_reg, new_best_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       slot_reg;
    logic [FR_W-1:0]  frame_reg;
    logic             phase_reg;

    // Decimal increment: each nibble at 9 rolls to 0 and carries upward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Game FSM: next state and score bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        score_next    = score_reg;
        best_next     = best_reg;
        new_best_next = new_best_reg;
        if (game_start) begin
            state_next    = PLAY;
            score_next    = 16'h0000;
            new_best_next = 1'b0;
        end else if (game_over) begin
            if (state_reg == PLAY) begin
                state_next = OVER;
                // Packed BCD orders the same way as the decimal value.
                if (score_reg > best_reg) begin
                    best_next     = score_reg;
                    new_best_next = 1'b1;
                end else begin
                    new_best_next = 1'b0;
                end
            end
        end else if (point && state_reg == PLAY && score_reg != 16'h9999) begin
            score_next = bcd_inc(score_reg);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            score_reg    <= 16'h0000;
            best_reg     <= 16'h0000;
            new_best_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            score_reg    <= score_next;
            best_reg     <= best_next;
            new_best_reg <= new_best_next;
        end
    end

    assign score_bcd = score_reg;
    assign best_bcd  = best_reg;
    assign new_best  = new_best_reg;

    // ------------------------------------------------------------------
    // Scan timing and flash phase
    // ------------------------------------------------------------------
    logic cnt_wrap;
    logic frame_wrap;

    assign cnt_wrap   = (cnt_reg == CNT_MAX);
    // A frame completes when slot 7 hands over to slot 0.
    assign frame_wrap = cnt_wrap && (slot_reg == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            slot_reg  <= 3'd0;
            frame_reg <= '0;
            phase_reg <= 1'b1;
        end else begin
            if (cnt_wrap) begin
                cnt_reg  <= '0;
                slot_reg <= slot_reg + 3'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            // The flash timebase only runs while the game is over, so every
            // OVER period starts with the display visible.
            if (state_reg != OVER) begin
                frame_reg <= '0;
                phase_reg <= 1'b1;
            end else if (frame_wrap) begin
                if (frame_reg == FR_MAX) begin
                    frame_reg <= '0;
                    phase_reg <= ~phase_reg;
                end else begin
                    frame_reg <= frame_reg + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-slot blanking: leading zeros within each 4-digit group, and
    // flashing of the score group (plus the best group on a new record).
    // ------------------------------------------------------------------
    logic [31:0] disp_all;
    logic [7:0]  lz_blank;
    logic [7:0]  flash_blank;
    logic        flash_on;

    assign disp_all = {best_reg, score_reg};
    assign flash_on = (state_reg == OVER) && !phase_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            // Digit k is a leading zero when it and all higher digits of
            // its group are zero; the ones digit always shows.
            if ((gi % 4) == 0) begin : g_ones
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = (disp_all[(gi/4)*16+15 : gi*4] == '0);
            end

            if (gi < 4) begin : g_score
                assign flash_blank[gi] = flash_on;
            end else begin : g_best
                assign flash_blank[gi] = flash_on && new_best_reg;
            end
        end
    endgenerate

    logic [3:0] digit_next;
    logic       blank_next;
    logic [7:0] an_next;

    always_comb begin
        digit_next = disp_all[{slot_reg, 2'b00} +: 4];
        blank_next = lz_blank[slot_reg] | flash_blank[slot_reg];
        an_next    = 8'hFF;
        if (!blank_next) begin
            an_next = ~(8'd1 << slot_reg);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
            blank <= 1'b1;
            an    <= 8'hFF;
        end else begin
            digit <= digit_next;
            blank <= blank_next;
            an    <= an_next;
        end
    end

endmodule
